// File: rtl/scratch_arbiter.sv
// scratch_arbiter: round-robin sharing of one scratchpad SRAM between two requesters; burst lock optional via SCRATCH_ARB_LOCK_EN.
// Latency: grant combinational, SRAM command registered one cycle after transfer, rvalid RD_LAT cycles after scratch_read.
// Backpressure: the losing port sees gnt=0 and holds its request; one access accepted per cycle.
module scratch_arbiter #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 1024,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   input  logic              lock0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   input  logic              lock1,
   output logic [DATA_W-1:0] rdata,
   output logic              scratch_read,
   output logic              scratch_write,
   output logic [ADDR_W-1:0] scratch_addr,
   output logic [DATA_W-1:0] scratch_in,
   input  logic [DATA_W-1:0] scratch_out
);

   logic              last_gnt;
   logic              allow0;
   logic              allow1;
   logic              xfer;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              rd_own;
   logic [RD_LAT-1:0] pipe_vld;
   logic [RD_LAT-1:0] pipe_own;

`ifdef SCRATCH_ARB_LOCK_EN
   typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} lock_state_t;
   lock_state_t state;
   lock_state_t state_nxt;

   always_ff @(posedge clk) begin
      if (n_rst) state <= OPEN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OPEN: begin
            if (gnt0 && lock0)      state_nxt = LOCK0;
            else if (gnt1 && lock1) state_nxt = LOCK1;
         end
         LOCK0:   if (gnt0 && !lock0) state_nxt = OPEN;
         LOCK1:   if (gnt1 && !lock1) state_nxt = OPEN;
         default: state_nxt = OPEN;
      endcase
   end

   // the owner of a lock is served alone, even while it is idle
   assign allow0 = (state != LOCK1);
   assign allow1 = (state != LOCK0);
`else
   logic unused_lock;
   assign unused_lock = lock0 | lock1;
   assign allow0      = 1'b1;
   assign allow1      = 1'b1;
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!n_rst) begin
         if (req0 && allow0 && (!req1 || !allow1 || last_gnt)) gnt0 = 1'b1;
         else if (req1 && allow1)                             gnt1 = 1'b1;
      end
   end

   assign xfer      = gnt0 | gnt1;
   assign win_we    = gnt1 ? we1    : we0;
   assign win_addr  = gnt1 ? addr1  : addr0;
   assign win_wdata = gnt1 ? wdata1 : wdata0;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         last_gnt      <= 1'b1;
         scratch_read  <= 1'b0;
         scratch_write <= 1'b0;
         scratch_addr  <= '0;
         scratch_in    <= '0;
         rd_own        <= 1'b0;
         pipe_vld      <= '0;
         pipe_own      <= '0;
      end else begin
         scratch_read  <= xfer & ~win_we;
         scratch_write <= xfer &  win_we;
         if (xfer) begin
            last_gnt     <= gnt1;
            scratch_addr <= win_addr;
            scratch_in   <= win_wdata;
            rd_own       <= gnt1;
         end
         // owner tag travels alongside the read strobe until the SRAM data lands
         pipe_vld[0] <= scratch_read;
         pipe_own[0] <= rd_own;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_own[i] <= pipe_own[i-1];
         end
      end
   end

   assign rvalid0 = pipe_vld[RD_LAT-1] & ~pipe_own[RD_LAT-1] & ~n_rst;
   assign rvalid1 = pipe_vld[RD_LAT-1] &  pipe_own[RD_LAT-1] & ~n_rst;
   assign rdata   = scratch_out;

endmodule

// File: tb/tb_scratch_arbiter.sv
// Bench for scratch_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of arbitration, SRAM command and read return.
module tb_scratch_arbiter;
   localparam int ADDR_W = 17;
   localparam int DATA_W = 1024;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              req0, we0, lock0, req1, we1, lock1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic              scratch_read, scratch_write;
   logic [ADDR_W-1:0] scratch_addr;
   logic [DATA_W-1:0] scratch_in, scratch_out;

   always #5 clk = ~clk;

   scratch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .n_rst(n_rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0), .lock0(lock0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1), .lock1(lock1),
      .rdata(rdata), .scratch_read(scratch_read), .scratch_write(scratch_write),
      .scratch_addr(scratch_addr), .scratch_in(scratch_in), .scratch_out(scratch_out)
   );

   // SRAM with RD_LAT cycles from the read-strobe cycle to valid data
   logic [DATA_W-1:0] sram [int];
   logic [DATA_W-1:0] sr_pipe [1:RD_LAT];
   always @(posedge clk) begin
      if (scratch_write) sram[int'(scratch_addr)] = scratch_in;
      if (scratch_read)
         sr_pipe[1] <= sram.exists(int'(scratch_addr)) ? sram[int'(scratch_addr)] : '0;
      else
         sr_pipe[1] <= {(DATA_W/32){32'hDEADBEEF}};
      for (int i = 2; i <= RD_LAT; i++) sr_pipe[i] <= sr_pipe[i-1];
   end
   assign scratch_out = sr_pipe[RD_LAT];

   typedef struct {
      int                due;
      bit                own;
      logic [DATA_W-1:0] data;
   } rd_t;

   rd_t               pend[$];
   logic [DATA_W-1:0] mmem [int];
   int                last_m = 1;
   bit                e_sread = 1'b0, e_swrite = 1'b0;
   logic [ADDR_W-1:0] e_saddr = '0;
   logic [DATA_W-1:0] e_sin = '0;
   int                cyc = 0, errors = 0, checks = 0;
   bit                s_gnt0, s_gnt1, s_rv0, s_rv1, s_sread, s_swrite, m_gnt0, m_gnt1;
   logic [ADDR_W-1:0] s_saddr;
   logic [DATA_W-1:0] s_rdata;
   logic [ADDR_W-1:0] addr_tab [6] = '{17'h00000, 17'h00010, 17'h1FFFF, 17'h00ABC, 17'h10000, 17'h00001};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got[63:0]=%h want[63:0]=%h", nm, cyc, act[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W/32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic step(input bit rst,
                       input bit r0, input bit w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input bit r1, input bit w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      bit                eg0, eg1, erv0, erv1, w;
      logic [DATA_W-1:0] erd, d;
      logic [ADDR_W-1:0] a;
      rd_t               p;
      @(posedge clk); #1;
      n_rst = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = 1'($urandom_range(0, 1));
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (rst) while (pend.size() > 0 && pend[$].due >= cyc) void'(pend.pop_back());
      eg0 = 1'b0; eg1 = 1'b0;
      if (!rst) begin
         if (r0 && r1) begin
            if (last_m == 1) eg0 = 1'b1; else eg1 = 1'b1;
         end else if (r0) eg0 = 1'b1;
         else if (r1)     eg1 = 1'b1;
      end
      erv0 = 1'b0; erv1 = 1'b0; erd = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         p = pend.pop_front();
         if (p.own) erv1 = 1'b1; else erv0 = 1'b1;
         erd = p.data;
      end
      s_gnt0 = gnt0; s_gnt1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1; s_rdata = rdata;
      s_sread = scratch_read; s_swrite = scratch_write; s_saddr = scratch_addr;
      m_gnt0 = eg0; m_gnt1 = eg1;
      chk("gnt0", 64'(gnt0), 64'(eg0));
      chk("gnt1", 64'(gnt1), 64'(eg1));
      chk("rvalid0", 64'(rvalid0), 64'(erv0));
      chk("rvalid1", 64'(rvalid1), 64'(erv1));
      if (erv0 || erv1) chkw("rdata", rdata, erd);
      chk("scratch_read", 64'(scratch_read), 64'(e_sread));
      chk("scratch_write", 64'(scratch_write), 64'(e_swrite));
      chk("scratch_addr", 64'(scratch_addr), 64'(e_saddr));
      chkw("scratch_in", scratch_in, e_sin);
      if (rst) begin
         e_sread = 1'b0; e_swrite = 1'b0; e_saddr = '0; e_sin = '0; last_m = 1;
      end else if (eg0 || eg1) begin
         w = eg1 ? w1 : w0; a = eg1 ? a1 : a0; d = eg1 ? d1 : d0;
         e_sread = !w; e_swrite = w; e_saddr = a; e_sin = d; last_m = eg1 ? 1 : 0;
         if (w) mmem[int'(a)] = d;
         else begin
            p.due  = cyc + 1 + RD_LAT;
            p.own  = eg1;
            p.data = mmem.exists(int'(a)) ? mmem[int'(a)] : '0;
            pend.push_back(p);
         end
      end else begin
         e_sread = 1'b0; e_swrite = 1'b0;
      end
   endtask

   task automatic idle(input bit rst);
      step(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [DATA_W-1:0] pat, pat2, pat3;
      logic [5:0]        conf_exp;
      bit                hold0, hold1, r0, w0, r1, w1, rst;
      logic [ADDR_W-1:0] a0, a1;
      logic [DATA_W-1:0] d0, d1;
      pat  = {(DATA_W/8){8'hA5}};
      pat2 = {(DATA_W/16){16'h1234}};
      pat3 = {(DATA_W/16){16'hBEEF}};
      conf_exp = 6'b101010;
      n_rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // reset held with both ports requesting
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
         chk("rst_gnt0", 64'(s_gnt0), 64'd0);
         chk("rst_gnt1", 64'(s_gnt1), 64'd0);
         chk("rst_saddr", 64'(s_saddr), 64'd0);
      end

      // conflict, all reads: 0,1,0,1,0,1
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b0, 17'h00020, '0, 1'b1, 1'b0, 17'h00021, '0);
         chk("conf_seq_gnt1", 64'(s_gnt1), 64'(conf_exp[i]));
         if (i > 0) chk("conf_sread", 64'(s_sread), 64'd1);
      end
      for (int i = 0; i < RD_LAT + 2; i++) idle(1'b0);

      // single port write then read back
      step(1'b0, 1'b1, 1'b1, 17'h00010, pat, 1'b0, 1'b0, '0, '0);
      chk("sp_wr_gnt0", 64'(s_gnt0), 64'd1);
      step(1'b0, 1'b1, 1'b0, 17'h00010, '0, 1'b0, 1'b0, '0, '0);
      chk("sp_swrite", 64'(s_swrite), 64'd1);
      chk("sp_saddr", 64'(s_saddr), 64'h10);
      idle(1'b0);
      chk("sp_sread", 64'(s_sread), 64'd1);
      for (int j = 1; j <= RD_LAT; j++) begin
         idle(1'b0);
         chk("sp_rvalid0", 64'(s_rv0), (j == RD_LAT) ? 64'd1 : 64'd0);
         chk("sp_rvalid1", 64'(s_rv1), 64'd0);
      end
      chkw("sp_rdata", s_rdata, pat);

      // back-to-back reads from both ports, each owner gets its own word
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h1FFFF, pat2);
      step(1'b0, 1'b1, 1'b1, 17'h00000, pat3, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 17'h1FFFF, '0);
      step(1'b0, 1'b1, 1'b0, 17'h00000, '0, 1'b0, 1'b0, '0, '0);
      for (int j = 1; j <= RD_LAT + 1; j++) begin
         idle(1'b0);
         if (j == RD_LAT) begin
            chk("lat_rvalid1", 64'(s_rv1), 64'd1);
            chkw("lat_rdata1", s_rdata, pat2);
         end
         if (j == RD_LAT + 1) begin
            chk("lat_rvalid0", 64'(s_rv0), 64'd1);
            chkw("lat_rdata0", s_rdata, pat3);
         end
      end

      // reset the cycle after the read strobe: that read never returns
      step(1'b0, 1'b1, 1'b0, 17'h00010, '0, 1'b0, 1'b0, '0, '0);
      idle(1'b0);
      chk("mid_sread", 64'(s_sread), 64'd1);
      idle(1'b1);
      idle(1'b1);
      for (int j = 0; j < RD_LAT + 2; j++) begin
         idle(1'b0);
         chk("mid_no_rvalid", 64'({s_rv0, s_rv1}), 64'd0);
      end
      step(1'b0, 1'b1, 1'b0, 17'h00001, '0, 1'b1, 1'b0, 17'h00002, '0);
      chk("mid_first_conflict_gnt0", 64'(s_gnt0), 64'd1);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 17'h00002, '0);

      // randomized traffic, losers hold their request stable
      hold0 = 1'b0; hold1 = 1'b0;
      r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0; r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!hold0) begin
            r0 = ($urandom_range(0, 99) < 70); w0 = 1'($urandom_range(0, 1));
            a0 = addr_tab[$urandom_range(0, 5)]; d0 = rand_word();
         end
         if (!hold1) begin
            r1 = ($urandom_range(0, 99) < 70); w1 = 1'($urandom_range(0, 1));
            a1 = addr_tab[$urandom_range(0, 5)]; d1 = rand_word();
         end
         step(rst, r0, w0, a0, d0, r1, w1, a1, d1);
         hold0 = r0 && !m_gnt0 && !rst;
         hold1 = r1 && !m_gnt1 && !rst;
      end
      for (int j = 0; j < RD_LAT + 2; j++) idle(1'b0);
      chk("drained", 64'(pend.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/scratch_arbiter.md
Name: scratch_arbiter

Overview:
- Shares the single external 1024-bit scratchpad SRAM between two scrypt core requesters.
- Performs round-robin arbitration between the two ports.
- Drives the registered SRAM command and routes read data back to the port that issued it.
- Sits between two scrypt cores and the top-level scratch_* pins, so the hasher can run two nonces concurrently.

Parameters:
ADDR_W, 17, scratch address width
DATA_W, 1024, scratch word width
RD_LAT, 1, SRAM read latency in cycles from registered scratch_read to valid scratch_out (legal: 1..4)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous, active-high (1 = reset)
req0  in  1  requester 0 access request
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 accepted this cycle
rvalid0  out  1  rdata valid for requester 0
lock0  in  1  requester 0 burst lock (used only with the optional feature)
req1, we1, addr1, wdata1, gnt1, rvalid1, lock1  same as port 0, for requester 1
rdata  out  DATA_W  read data, shared by both ports; equals scratch_out
scratch_read  out  1  SRAM read strobe, registered
scratch_write  out  1  SRAM write strobe, registered
scratch_addr  out  ADDR_W  SRAM address, registered
scratch_in  out  DATA_W  SRAM write data, registered
scratch_out  in  DATA_W  SRAM read data

Behaviour:
- Handshake:
  - A request transfers on a rising edge where reqX=1 and gntX=1.
  - gntX is combinational from reqX, the priority state and reset.
  - The requester holds we/addr/wdata stable while reqX=1 and gntX=0.
  - At most one gnt per cycle. gntX never asserts without reqX.
  - A requester may keep reqX high across consecutive grants (back-to-back).
- Arbitration:
  - Register last_gnt, reset value 1, so port 0 wins the first conflict.
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port != last_gnt is granted.
  - last_gnt updates on every transfer.
  - Writes and reads are treated identically.
- SRAM command:
  - On a transfer edge, scratch_read <= ~we, scratch_write <= we, scratch_addr <= addr, scratch_in <= wdata of the winner.
  - No transfer: scratch_read/scratch_write <= 0; scratch_addr and scratch_in hold.
  - scratch_read and scratch_write are never both 1.
  - Full throughput: 1 access per cycle.
- Read return:
  - A tag shift register of depth RD_LAT carries {valid, owner} per issued read.
  - rvalidX = 1 for exactly one cycle, RD_LAT cycles after the cycle scratch_read=1 for that owner's read.
  - rdata = scratch_out (combinational passthrough, no register).
  - Reads return in issue order. Writes produce no rvalid.
- Reset values:
  - scratch_read = 0, scratch_write = 0, scratch_addr = 0, scratch_in = 0.
  - gnt0 = gnt1 = 0 (forced while n_rst=1).
  - rvalid0 = rvalid1 = 0; tag pipe cleared; last_gnt = 1; lock state = OPEN.
- Reset mid-operation: in-flight reads are dropped (no rvalid after reset); requesters must reissue.
- Read-after-write to the same address from different ports: ordering is the grant order; no forwarding.

Optional Feature:
- Macro: SCRATCH_ARB_LOCK_EN.
- Defined — burst lock FSM with states OPEN, LOCK0, LOCK1:
  - OPEN -> LOCKx on a transfer from port x with lockx=1.
  - In LOCKx only port x may be granted; the other port's gnt is forced 0 even if port x is idle.
  - LOCKx -> OPEN on a transfer from port x with lockx=0.
  - last_gnt still updates on every transfer.
  - Used for ROMix write-phase bursts.
- Not defined:
  - lock0/lock1 are ignored (left unconnected internally); FSM absent.
  - Pure round-robin as above.

Test Plan:
- Reset: n_rst=1 for 2 cycles while req0=req1=1 -> gnt0=gnt1=0, scratch_read=scratch_write=0, scratch_addr=0, rvalid0=rvalid1=0.
- Single port: req0 write addr=0x00010, wdata=0xA5 repeated; then read 0x00010, RD_LAT=1 -> scratch_write=1 the next cycle with scratch_addr=0x00010; read strobe one cycle after its grant; rvalid0=1 exactly 1 cycle later with rdata=0xA5…; rvalid1 stays 0.
- Conflict: req0 and req1 both held high for 6 cycles, all reads -> grants alternate 0,1,0,1,0,1 starting with port 0; scratch_read=1 every cycle; rvalids alternate with matching owners.
- Latency sweep: RD_LAT=3, port 1 reads 0x1FFFF then port 0 reads 0x00000 back-to-back -> rvalid1 at issue+3, rvalid0 at issue+4, each carrying the correct scratch_out word.
- Reset mid-read: RD_LAT=2, assert n_rst the cycle after scratch_read=1 -> no rvalid ever appears for that read; after release, port 0 wins the first conflict.
- SCRATCH_ARB_LOCK_EN: port 0 issues 4 writes with lock0=1 then 1 with lock0=0, req1 held high throughout -> gnt1=0 through all 5 transfers; gnt1=1 on the next cycle.
